// File: rtl/compuertas_logicas_acum_if.sv
// Operand/result stream bundle for compuertas_logicas_acum.
//   sel        operation code, sampled with the first operand of a result
//   ent        operand data          ent_valid / ent_ready  operand handshake
//   sal        result data           sal_valid / sal_ready  result handshake
//   err_sel    invalid opcode flag for the result currently on sal
// slave modport is the accumulator's view; master is the producer/consumer side.
interface compuertas_logicas_acum_if #(
    parameter int unsigned ANCHO = 8
);
    logic [2:0]       sel;
    logic [ANCHO-1:0] ent;
    logic             ent_valid;
    logic             ent_ready;
    logic [ANCHO-1:0] sal;
    logic             sal_valid;
    logic             sal_ready;
    logic             err_sel;

    modport slave (
        input  sel, ent, ent_valid, sal_ready,
        output ent_ready, sal, sal_valid, err_sel
    );

    modport master (
        output sel, ent, ent_valid, sal_ready,
        input  ent_ready, sal, sal_valid, err_sel
    );
endinterface

// File: rtl/compuertas_logicas_acum.sv
// Sequential gate reducer: folds NUM_OPER operands of ANCHO bits through
// AND/OR/XOR (optionally inverted once at the end) and presents the result
// on a valid/ready stream.
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   act      enable; 0 blocks operand acceptance, result handshake unaffected
//   ocupado  1 while accumulating or holding a result
//   bus      operand/result streams (compuertas_logicas_acum_if.slave)
module compuertas_logicas_acum #(
    parameter int unsigned ANCHO    = 8,
    parameter int unsigned NUM_OPER = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      act,
    output logic                      ocupado,
    compuertas_logicas_acum_if.slave  bus
);
    localparam int unsigned   CW     = (NUM_OPER > 1) ? $clog2(NUM_OPER) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(NUM_OPER - 1);

    typedef enum logic [1:0] {IDLE, ACUM, SALIDA} estado_t;

    estado_t          state_q, state_d;
    logic [ANCHO-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [ANCHO-1:0] sal_q, sal_d;
    logic             err_q, err_d;
    logic             ready;
    logic             acepta;
    logic [ANCHO-1:0] paso;

    function automatic logic [ANCHO-1:0] operar(input logic [2:0] s,
                                                input logic [ANCHO-1:0] a,
                                                input logic [ANCHO-1:0] b);
        case (s)
            3'b001, 3'b100: operar = a & b;
            3'b010, 3'b101: operar = a | b;
            3'b011, 3'b110: operar = a ^ b;
            default:        operar = '0;
        endcase
    endfunction

    function automatic logic [ANCHO-1:0] finalizar(input logic [2:0] s,
                                                   input logic [ANCHO-1:0] r);
        case (s)
            3'b100, 3'b101, 3'b110: finalizar = ~r;
            3'b001, 3'b010, 3'b011: finalizar = r;
            default:                finalizar = '0;
        endcase
    endfunction

    // Reset also forces ready low so nothing is offered as accepted while held in reset.
    assign ready         = rst_n & act & (state_q != SALIDA);
    assign acepta        = bus.ent_valid & ready;
    assign paso          = operar(sel_q, acc_q, bus.ent);

    assign bus.ent_ready = ready;
    assign bus.sal       = sal_q;
    assign bus.sal_valid = (state_q == SALIDA);
    assign bus.err_sel   = err_q;
    assign ocupado       = (state_q == ACUM) || (state_q == SALIDA);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        sal_d   = sal_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (acepta) begin
                    sel_d   = bus.sel;
                    acc_d   = bus.ent;
                    cnt_d   = CW'(1);
                    state_d = ACUM;
                end
            end
            ACUM: begin
                if (acepta) begin
                    acc_d = paso;
                    if (cnt_q == ULTIMO) begin
                        // cnt holds on the last beat so it never wraps at power-of-two NUM_OPER
                        sal_d   = finalizar(sel_q, paso);
                        err_d   = (sel_q == 3'b000) || (sel_q == 3'b111);
                        state_d = SALIDA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            SALIDA: begin
                if (bus.sal_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            sal_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            sal_q   <= sal_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_compuertas_logicas_acum.sv
// Self-checking bench for compuertas_logicas_acum (ANCHO=8, NUM_OPER=3).
module tb_compuertas_logicas_acum;
    logic clk;
    logic rst_n;
    logic act;
    logic ocupado;
    int   n_cmp;
    int   n_bad;

    compuertas_logicas_acum_if #(.ANCHO(8)) bus ();

    compuertas_logicas_acum #(
        .ANCHO    (8),
        .NUM_OPER (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .act     (act),
        .ocupado (ocupado),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-bit reference: count the ones across the three operands and
    // apply the gate rule to that count.
    function automatic logic [7:0] ref_sal(input logic [2:0] s, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] c);
        logic [7:0] r;
        int unsigned n;
        for (int i = 0; i < 8; i++) begin
            n = 32'(a[i]) + 32'(b[i]) + 32'(c[i]);
            case (s)
                3'd1, 3'd4: r[i] = (n == 3);
                3'd2, 3'd5: r[i] = (n != 0);
                3'd3, 3'd6: r[i] = (n % 2 == 1);
                default:    r[i] = 1'b0;
            endcase
        end
        if (s >= 3'd4 && s <= 3'd6) r = ~r;
        return r;
    endfunction

    // One complete operation: three beats (optional idle gaps and an act stall
    // before beat stall_beat), then the result held for 'hold' cycles before sal_ready.
    task automatic run_op(input logic [2:0] s, input logic [7:0] o0, input logic [7:0] o1,
                          input logic [7:0] o2, input bit gaps, input int stall_beat,
                          input int stall_len, input int hold, input string nm);
        logic [7:0] ops [3];
        logic [7:0] exp_sal;
        logic       exp_err;
        int         g;
        ops[0] = o0; ops[1] = o1; ops[2] = o2;
        exp_sal = ref_sal(s, o0, o1, o2);
        exp_err = (s == 3'b000) || (s == 3'b111);
        bus.sal_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            g = gaps ? int'($urandom_range(0, 2)) : 0;
            for (int j = 0; j < g; j++) begin
                bus.ent_valid = 1'b0;
                bus.ent = 8'($urandom);
                bus.sel = 3'($urandom);
                @(negedge clk);
                n_cmp++;
                if (bus.sal_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s gap_sal_valid got=%b exp=0", nm, bus.sal_valid);
                end
            end
            if (k == stall_beat) begin
                act = 1'b0;
                bus.ent_valid = 1'b1;
                bus.ent = ops[k];
                bus.sel = 3'b001;
                for (int j = 0; j < stall_len; j++) begin
                    #1;
                    n_cmp++;
                    if (bus.ent_ready !== 1'b0) begin
                        n_bad++;
                        $display("FAIL %s stall_ent_ready got=%b exp=0", nm, bus.ent_ready);
                    end
                    @(negedge clk);
                    n_cmp++;
                    if (bus.sal_valid !== 1'b0 || ocupado !== (k > 0)) begin
                        n_bad++;
                        $display("FAIL %s stall_state sal_valid=%b ocupado=%b exp 0,%b",
                                 nm, bus.sal_valid, ocupado, (k > 0));
                    end
                end
                act = 1'b1;
            end
            bus.sel = (k == 0) ? s : 3'($urandom);
            bus.ent = ops[k];
            bus.ent_valid = 1'b1;
            #1;
            n_cmp++;
            if (bus.ent_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL %s beat%0d_ent_ready got=%b exp=1", nm, k, bus.ent_ready);
            end
            @(negedge clk);
            if (k < 2) begin
                n_cmp++;
                if (bus.sal_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s early_sal_valid beat%0d got=%b exp=0", nm, k, bus.sal_valid);
                end
            end
        end
        bus.ent_valid = 1'b0;
        bus.sel = 3'($urandom);
        for (int h = 0; h <= hold; h++) begin
            n_cmp++;
            if (bus.sal_valid !== 1'b1 || bus.sal !== exp_sal || bus.err_sel !== exp_err ||
                bus.ent_ready !== 1'b0 || ocupado !== 1'b1) begin
                n_bad++;
                $display("FAIL %s result[%0d] got v=%b sal=%h err=%b rdy=%b ocu=%b exp v=1 sal=%h err=%b rdy=0 ocu=1",
                         nm, h, bus.sal_valid, bus.sal, bus.err_sel, bus.ent_ready, ocupado,
                         exp_sal, exp_err);
            end
            if (h == hold) bus.sal_ready = 1'b1;
            @(negedge clk);
        end
        bus.sal_ready = 1'b0;
        n_cmp++;
        if (bus.sal_valid !== 1'b0 || bus.ent_ready !== 1'b1 || ocupado !== 1'b0) begin
            n_bad++;
            $display("FAIL %s release got v=%b rdy=%b ocu=%b exp v=0 rdy=1 ocu=0",
                     nm, bus.sal_valid, bus.ent_ready, ocupado);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        act = 1'b1;
        bus.ent_valid = 1'b1;
        bus.ent = 8'hA5;
        bus.sel = 3'b001;
        bus.sal_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.sal !== 8'h00 || bus.sal_valid !== 1'b0 || bus.err_sel !== 1'b0 ||
            bus.ent_ready !== 1'b0 || ocupado !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got sal=%h v=%b err=%b rdy=%b ocu=%b exp all 0",
                     bus.sal, bus.sal_valid, bus.err_sel, bus.ent_ready, ocupado);
        end
        bus.ent_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.ent_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready got=%b exp=1", bus.ent_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_ops();
        run_op(3'b001, 8'hF0, 8'h3C, 8'hFF, 1'b0, -1, 0, 0, "and");
        run_op(3'b101, 8'h01, 8'h02, 8'h04, 1'b0, -1, 0, 0, "nor");
        run_op(3'b110, 8'hAA, 8'h55, 8'h0F, 1'b0, -1, 0, 0, "xnor");
    endtask

    task automatic test_backpressure();
        run_op(3'b011, 8'h3C, 8'h0F, 8'hF1, 1'b0, -1, 0, 5, "backpressure");
    endtask

    task automatic test_act_stall();
        run_op(3'b010, 8'h11, 8'h22, 8'h44, 1'b0, 2, 4, 0, "act_stall");
    endtask

    task automatic test_invalid();
        run_op(3'b000, 8'hFF, 8'hFF, 8'hFF, 1'b0, -1, 0, 0, "inv000");
        run_op(3'b111, 8'hFF, 8'hFF, 8'hFF, 1'b0, -1, 0, 0, "inv111");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            run_op(3'($urandom_range(1, 6)), 8'($urandom), 8'($urandom), 8'($urandom),
                   1'b0, -1, 0, 0, "b2b");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_op(3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1,
                   int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                   int'($urandom_range(0, 3)), "random");
    endtask

    task automatic test_async_reset();
        run_op(3'b001, 8'hFF, 8'hFF, 8'hFF, 1'b0, -1, 0, 0, "pre_reset");
        bus.sel = 3'b010;
        bus.ent = 8'h81;
        bus.ent_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus.ent_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.sal !== 8'h00 || bus.sal_valid !== 1'b0 || bus.err_sel !== 1'b0 ||
            bus.ent_ready !== 1'b0 || ocupado !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset got sal=%h v=%b err=%b rdy=%b ocu=%b exp all 0",
                     bus.sal, bus.sal_valid, bus.err_sel, bus.ent_ready, ocupado);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(3'b011, 8'h01, 8'h01, 8'h01, 1'b0, -1, 0, 0, "post_reset_xor");
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_ops();
        test_backpressure();
        test_act_stall();
        test_back_to_back();
        test_random();
        test_invalid();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
